sram_arbiter: RTL and testbench

Shares the accelerator's single-port 256×32 scratch SRAM between up to `NUM_REQ` requesters: the Wishbone slave controller, matrix multiplication and matrix convolution. Each requester gets a uniform req/done handshake with fixed latency. The block sits between the requesters and the SRAM macro. It completes an access on the SRAM's known one-cycle read latency, never by comparing data values.

---
 rtl/accel_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/sram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Accelerator-wide constants shared by the scratch-SRAM arbiter and its requesters.
package accel_pkg;

   localparam int SRAM_AW   = 8;
   localparam int SRAM_DW   = 32;
   localparam int SRAM_BE_W = 4;

   localparam int REQ_WB    = 0;
   localparam int REQ_MMUL  = 1;
   localparam int REQ_MCONV = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_CAPTURE = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts one past the last winner and wraps.
module rr_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   gnt_idx_o,
   output logic               valid_o
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      // NOTE: every output gets a default before the search, so no path leaves one unassigned (no latch).
      gnt_o     = '0;
      gnt_idx_o = '0;
      valid_o   = 1'b0;
      idx       = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         idx = IDX_W'((int'(last_i) + off) % NUM_REQ);
         if (!valid_o && req_i[idx]) begin
            valid_o    = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = idx;
         end
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the single-port scratch SRAM: IDLE arbitrates, ACCESS drives the macro for
// one cycle, CAPTURE samples Do0 and pulses done to the owner.
module sram_arbiter
   import accel_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int AW      = SRAM_AW,
   parameter int DW      = SRAM_DW
) (
   input  logic                         wb_clk_i,
   input  logic                         wb_rst_i,
   input  logic [NUM_REQ-1:0]           req_i,
   input  logic [NUM_REQ-1:0]           we_i,
   input  logic [SRAM_BE_W*NUM_REQ-1:0] be_i,
   input  logic [NUM_REQ*AW-1:0]        addr_i,
   input  logic [NUM_REQ*DW-1:0]        wdata_i,
   output logic [NUM_REQ-1:0]           grant_o,
   output logic [NUM_REQ-1:0]           done_o,
   output logic [DW-1:0]                rdata_o,
   output logic                         busy_o,
   output logic                         sram_en_o,
   output logic [SRAM_BE_W-1:0]         sram_we_o,
   output logic [AW-1:0]                sram_addr_o,
   output logic [DW-1:0]                sram_di_o,
   input  logic [DW-1:0]                sram_do_i
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_e             state_q, state_d;
   logic [NUM_REQ-1:0]     grant_q, grant_d;
   logic [NUM_REQ-1:0]     done_q, done_d;
   logic                   busy_q, busy_d;
   logic                   en_q, en_d;
   logic                   wr_q, wr_d;
   logic [SRAM_BE_W-1:0]   we_q, we_d;
   logic [AW-1:0]          addr_q, addr_d;
   logic [DW-1:0]          di_q, di_d;
   logic [DW-1:0]          rdata_q, rdata_d;
   logic [IDX_W-1:0]       last_q, last_d;

   logic [NUM_REQ-1:0]     req_masked;
   logic [NUM_REQ-1:0]     pick_gnt;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_valid;

   logic                   sel_we;
   logic [SRAM_BE_W-1:0]   sel_be;
   logic [AW-1:0]          sel_addr;
   logic [DW-1:0]          sel_wdata;

   // The port whose done is showing sits out one arbitration round.
   assign req_masked = req_i & ~done_q;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .req_i     (req_masked),
      .last_i    (last_q),
      .gnt_o     (pick_gnt),
      .gnt_idx_o (pick_idx),
      .valid_o   (pick_valid)
   );

   always_comb begin
      sel_we    = 1'b0;
      sel_be    = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick_gnt[i]) begin
            sel_we    = we_i[i];
            sel_be    = be_i[i*SRAM_BE_W +: SRAM_BE_W];
            sel_addr  = addr_i[i*AW +: AW];
            sel_wdata = wdata_i[i*DW +: DW];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      done_d  = '0;
      busy_d  = busy_q;
      en_d    = 1'b0;
      wr_d    = wr_q;
      we_d    = '0;
      addr_d  = '0;
      di_d    = '0;
      rdata_d = rdata_q;
      last_d  = last_q;

      unique case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d = ST_ACCESS;
               grant_d = pick_gnt;
               busy_d  = 1'b1;
               en_d    = 1'b1;
               wr_d    = sel_we;
               we_d    = sel_we ? sel_be : '0;
               addr_d  = sel_addr;
               di_d    = sel_wdata;
               last_d  = pick_idx;
            end
         end
         ST_ACCESS: begin
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            state_d = ST_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            done_d  = grant_q;
            if (!wr_q) rdata_d = sram_do_i;
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         en_q    <= 1'b0;
         wr_q    <= 1'b0;
         we_q    <= '0;
         addr_q  <= '0;
         di_q    <= '0;
         rdata_q <= '0;
         last_q  <= IDX_W'(NUM_REQ - 1);
      end else begin
         // NOTE: non-blocking updates so every register samples the pre-edge value of the others.
         state_q <= state_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         en_q    <= en_d;
         wr_q    <= wr_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         di_q    <= di_d;
         rdata_q <= rdata_d;
         last_q  <= last_d;
      end
   end

   assign grant_o     = grant_q;
   assign done_o      = done_q;
   assign rdata_o     = rdata_q;
   assign busy_o      = busy_q;
   assign sram_en_o   = en_q;
   assign sram_we_o   = we_q;
   assign sram_addr_o = addr_q;
   assign sram_di_o   = di_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM macro plus a transaction-level reference
// model (memory image, round-robin pointer, access timeline) checked every cycle.
module tb_sram_arbiter;
   import accel_pkg::*;

   localparam int N  = 3;
   localparam int AW = SRAM_AW;
   localparam int DW = SRAM_DW;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0]      req = '0;
   logic [N-1:0]      we = '0;
   logic [4*N-1:0]    be = '0;
   logic [N*AW-1:0]   addr = '0;
   logic [N*DW-1:0]   wdata = '0;
   logic [N-1:0]      grant, done;
   logic [DW-1:0]     rdata, sram_di, sram_do;
   logic              busy, sram_en;
   logic [3:0]        sram_we;
   logic [AW-1:0]     sram_addr;

   always #5 clk = ~clk;

   sram_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .req_i       (req),
      .we_i        (we),
      .be_i        (be),
      .addr_i      (addr),
      .wdata_i     (wdata),
      .grant_o     (grant),
      .done_o      (done),
      .rdata_o     (rdata),
      .busy_o      (busy),
      .sram_en_o   (sram_en),
      .sram_we_o   (sram_we),
      .sram_addr_o (sram_addr),
      .sram_di_o   (sram_di),
      .sram_do_i   (sram_do)
   );

   // SRAM macro: byte-masked write, read data on Do the cycle after EN; backdoor preload port.
   logic [31:0] sram_mem [256];
   logic        pl_en = 1'b0;
   logic [7:0]  pl_addr = '0;
   logic [31:0] pl_data = '0;

   always @(posedge clk) begin
      if (pl_en) sram_mem[pl_addr] <= pl_data;
      else if (sram_en) begin
         for (int b = 0; b < 4; b++)
            if (sram_we[b]) sram_mem[sram_addr][8*b +: 8] <= sram_di[8*b +: 8];
         if (sram_we == 4'h0) sram_do <= sram_mem[sram_addr];
      end
   end

   // Reference model state
   logic [31:0] ref_mem [256];
   int          cyc = 0;
   int          last_g = N - 1;
   int          free_at = 0;
   bit          act = 1'b0;
   int          t_start = 0;
   int          t_w = 0;
   logic        t_we = 1'b0;
   logic [3:0]  t_be = '0;
   logic [7:0]  t_addr = '0;
   logic [31:0] t_wdata = '0;
   logic [31:0] ref_rdata = '0;
   int          en_seen = 0;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int oh_idx(input logic [N-1:0] v);
      oh_idx = -1;
      for (int i = 0; i < N; i++) if (v[i]) oh_idx = i;
   endfunction

   task automatic set_port(input int p, input logic w, input logic [3:0] b,
                           input logic [7:0] a, input logic [31:0] d);
      we[p]             = w;
      be[p*4 +: 4]      = b;
      addr[p*AW +: AW]  = a;
      wdata[p*DW +: DW] = d;
   endtask

   // Per edge: a new access may start only once the previous one is three edges old,
   // excluding the port whose done pulse is on the inputs at that edge.
   task automatic model_edge();
      logic [N-1:0] elig;
      bit           found;
      int           p;
      if (rst) begin
         act       = 1'b0;
         last_g    = N - 1;
         free_at   = 0;
         ref_rdata = '0;
      end else begin
         if (act && cyc == t_start + 2 && !t_we) ref_rdata = ref_mem[t_addr];
         elig = req;
         if (act && cyc == t_start + 3) elig[t_w] = 1'b0;
         found = 1'b0;
         if (cyc >= free_at) begin
            for (int k = 1; k <= N; k++) begin
               p = (last_g + k) % N;
               if (!found && elig[p]) begin
                  found   = 1'b1;
                  act     = 1'b1;
                  t_start = cyc;
                  t_w     = p;
                  t_we    = we[p];
                  t_be    = be[p*4 +: 4];
                  t_addr  = addr[p*AW +: AW];
                  t_wdata = wdata[p*DW +: DW];
                  last_g  = p;
                  free_at = cyc + 3;
                  if (t_we)
                     for (int b = 0; b < 4; b++)
                        if (t_be[b]) ref_mem[t_addr][8*b +: 8] = t_wdata[8*b +: 8];
               end
            end
         end
      end
   endtask

   task automatic compare_outputs();
      logic         own, en_e;
      logic [N-1:0] g_e, d_e;
      own  = act && (cyc == t_start || cyc == t_start + 1);
      en_e = act && (cyc == t_start);
      g_e  = own ? N'(1 << t_w) : '0;
      d_e  = (act && cyc == t_start + 2) ? N'(1 << t_w) : '0;
      check("grant", grant, g_e);
      check("busy", busy, own);
      check("done", done, d_e);
      check("sram_en", sram_en, en_e);
      check("rdata", rdata, ref_rdata);
      if (en_e) begin
         check("sram_we", sram_we, t_we ? t_be : 4'h0);
         check("sram_addr", sram_addr, t_addr);
         if (t_we) check("sram_di", sram_di, t_wdata);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (sram_en) en_seen++;
      model_edge();
      compare_outputs();
   endtask

   task automatic do_access(input int p, input logic w, input logic [3:0] b,
                            input logic [7:0] a, input logic [31:0] d,
                            output int lat, output logic [31:0] rd, output int ens);
      int t0, cnt, en0;
      bit got;
      set_port(p, w, b, a, d);
      req[p] = 1'b1;
      t0 = cyc; en0 = en_seen; got = 1'b0; cnt = 0;
      while (!got && cnt < 20) begin
         step();
         cnt++;
         if (done[p]) got = 1'b1;
      end
      check("done_timeout", got, 1'b1);
      req[p] = 1'b0;
      lat = cyc - t0;
      rd  = rdata;
      ens = en_seen - en0;
      step();
   endtask

   task automatic drain();
      int cnt = 0;
      while ((req != '0 || busy) && cnt < 100) begin
         for (int p = 0; p < N; p++) if (done[p]) req[p] = 1'b0;
         step();
         cnt++;
      end
      check("drain_timeout", (req == '0 && !busy), 1'b1);
      step();
   endtask

   function automatic logic [31:0] preload_val(input int a);
      case (a)
         8'h00:   preload_val = 32'hA5A5_0F0F;
         8'h01:   preload_val = 32'h0000_0011;
         8'h02:   preload_val = 32'h0000_0022;
         8'h03:   preload_val = 32'h0000_0033;
         8'h20:   preload_val = 32'hFFFF_FFFF;
         default: preload_val = $urandom;
      endcase
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          lat, ens, ng, nd, cnt, r1, r2;
      logic [31:0] rd;
      logic [N-1:0] prev;
      int          order [6];
      logic [31:0] rds [6];
      logic [31:0] rr_words [3];
      rr_words = '{32'h11, 32'h22, 32'h33};

      // Preload memory while held in reset
      for (int i = 0; i < 256; i++) begin
         pl_en   = 1'b1;
         pl_addr = 8'(i);
         pl_data = preload_val(i);
         ref_mem[i] = pl_data;
         @(posedge clk);
         #1;
      end
      pl_en = 1'b0;

      check("rst_grant", grant, '0);
      check("rst_done", done, '0);
      check("rst_busy", busy, 1'b0);
      check("rst_rdata", rdata, '0);
      check("rst_en", sram_en, 1'b0);
      check("rst_we", sram_we, '0);
      check("rst_addr", sram_addr, '0);
      check("rst_di", sram_di, '0);
      rst = 1'b0;
      step();

      // Single write then read on port 0
      do_access(0, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF, lat, rd, ens);
      check("wr_latency", lat, 3);
      check("wr_en_cycles", ens, 1);
      do_access(0, 1'b0, 4'h0, 8'h10, 32'h0, lat, rd, ens);
      check("rd_latency", lat, 3);
      check("rd_en_cycles", ens, 1);
      check("rd_data_10", rd, 32'hDEADBEEF);

      // Byte enables on port 1
      do_access(1, 1'b1, 4'b0101, 8'h20, 32'h0000_0000, lat, rd, ens);
      do_access(1, 1'b0, 4'h0, 8'h20, 32'h0, lat, rd, ens);
      check("be_merge", rd, 32'hFF00FF00);

      // Top address on port 2, neighbour untouched
      do_access(2, 1'b1, 4'hF, 8'hFF, 32'h12345678, lat, rd, ens);
      do_access(2, 1'b0, 4'h0, 8'hFF, 32'h0, lat, rd, ens);
      check("addr_ff", rd, 32'h12345678);
      do_access(2, 1'b0, 4'h0, 8'h00, 32'h0, lat, rd, ens);
      check("addr_00", rd, 32'hA5A5_0F0F);

      // Three ports request together and hold: 0,1,2,0,1,2
      set_port(0, 1'b0, 4'h0, 8'h01, 32'h0);
      set_port(1, 1'b0, 4'h0, 8'h02, 32'h0);
      set_port(2, 1'b0, 4'h0, 8'h03, 32'h0);
      req = '1;
      ng = 0; nd = 0; cnt = 0; prev = '0;
      while (nd < 6 && cnt < 60) begin
         step();
         cnt++;
         if (grant != '0 && prev == '0 && ng < 6) begin
            order[ng] = oh_idx(grant);
            ng++;
         end
         prev = grant;
         if (done != '0) begin
            rds[nd] = rdata;
            nd++;
         end
      end
      req = '0;
      check("rr_done_count", nd, 6);
      for (int i = 0; i < 6; i++) begin
         check("rr_order", order[i], i % 3);
         check("rr_rdata", rds[i], rr_words[i % 3]);
      end
      step();

      // One port holding req through done: next grant four cycles later
      set_port(1, 1'b0, 4'h0, 8'h02, 32'h0);
      req[1] = 1'b1;
      ng = 0; nd = 0; cnt = 0; prev = '0; r1 = 0; r2 = 0;
      while (nd < 2 && cnt < 40) begin
         step();
         cnt++;
         if (grant != '0 && prev == '0) begin
            if (ng == 0) r1 = cyc; else r2 = cyc;
            ng++;
         end
         prev = grant;
         if (done[1]) nd++;
      end
      req[1] = 1'b0;
      check("hold_grant_count", ng, 2);
      check("hold_regrant_gap", r2 - r1, 4);
      step();

      // Reset asserted while in CAPTURE
      set_port(0, 1'b0, 4'h0, 8'h10, 32'h0);
      req[0] = 1'b1;
      step();
      step();
      check("pre_rst_busy", busy, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_grant", grant, '0);
      check("mid_rst_done", done, '0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_rdata", rdata, '0);
      check("mid_rst_en", sram_en, 1'b0);
      check("mid_rst_we", sram_we, '0);
      check("mid_rst_addr", sram_addr, '0);
      check("mid_rst_di", sram_di, '0);
      req[0] = 1'b0;
      step();
      rst = 1'b0;
      set_port(0, 1'b0, 4'h0, 8'h01, 32'h0);
      set_port(1, 1'b0, 4'h0, 8'h02, 32'h0);
      set_port(2, 1'b0, 4'h0, 8'h03, 32'h0);
      req = '1;
      step();
      check("post_rst_tie", grant, 3'b001);
      drain();

      // Randomised traffic against the reference model
      for (int c = 0; c < 600; c++) begin
         for (int p = 0; p < N; p++) begin
            if (done[p] && $urandom_range(0, 1) == 0) req[p] = 1'b0;
            if (!req[p] && $urandom_range(0, 3) == 0) begin
               set_port(p, 1'($urandom_range(0, 1)), 4'($urandom),
                        ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15)),
                        $urandom);
               req[p] = 1'b1;
            end
         end
         step();
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
